// File: rtl/eth_tx_sched.sv
// Transmit-path scheduler for the shared 10BASE-T link. It arbitrates audio and beacon frames,
// enforces the inter-frame gap and a frame timeout, and requests link pulses when the line is idle.
module eth_tx_sched #(
    parameter int IFG_BITS       = 96,
    parameter int NLP_PERIOD     = 160000,
    parameter int MAX_FRAME_BITS = 12304
) (
    input  logic clk,
    input  logic rst,
    input  logic eth_clk_stb,
    input  logic req_audio,
    input  logic req_beacon,
    output logic gnt_audio,
    output logic gnt_beacon,
    output logic tx_start,
    output logic tx_sel,
    input  logic tx_done,
    output logic nlp,
    output logic err_timeout,
    output logic busy
);

    localparam int IW = (NLP_PERIOD > 1)     ? $clog2(NLP_PERIOD)     : 1;
    localparam int GW = (IFG_BITS > 1)       ? $clog2(IFG_BITS)       : 1;
    localparam int FW = (MAX_FRAME_BITS > 1) ? $clog2(MAX_FRAME_BITS) : 1;

    localparam logic [IW-1:0] IDLE_MAX  = IW'(NLP_PERIOD - 1);
    localparam logic [GW-1:0] GAP_INIT  = GW'(IFG_BITS - 1);
    localparam logic [FW-1:0] FRAME_MAX = FW'(MAX_FRAME_BITS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_NLP  = 2'd3;

    logic [1:0]    state;
    logic          last_grant;   // 1 = beacon was granted last
    logic [IW-1:0] idle_cnt;
    logic [GW-1:0] gap_cnt;
    logic [FW-1:0] frame_cnt;
    logic          pick;         // 1 = beacon

    // On a tie, serve the source that did not win last time.
    always_comb begin
        pick = req_beacon;
        if (req_audio && req_beacon)
            pick = ~last_grant;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            last_grant  <= 1'b1;
            idle_cnt    <= '0;
            gap_cnt     <= '0;
            frame_cnt   <= '0;
            gnt_audio   <= 1'b0;
            gnt_beacon  <= 1'b0;
            tx_start    <= 1'b0;
            tx_sel      <= 1'b0;
            nlp         <= 1'b0;
            err_timeout <= 1'b0;
            busy        <= 1'b0;
        end else begin
            gnt_audio   <= 1'b0;
            gnt_beacon  <= 1'b0;
            tx_start    <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (eth_clk_stb) begin
                        // A pending frame beats a due link pulse.
                        if (req_audio || req_beacon) begin
                            gnt_audio  <= ~pick;
                            gnt_beacon <= pick;
                            tx_start   <= 1'b1;
                            tx_sel     <= pick;
                            last_grant <= pick;
                            frame_cnt  <= '0;
                            state      <= S_BUSY;
                            busy       <= 1'b1;
                        end else if (idle_cnt == IDLE_MAX) begin
                            nlp   <= 1'b1;
                            state <= S_NLP;
                            busy  <= 1'b1;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
                end
                S_BUSY: begin
                    if (tx_done) begin
                        gap_cnt <= GAP_INIT;
                        state   <= S_GAP;
                    end else if (eth_clk_stb) begin
                        if (frame_cnt == FRAME_MAX) begin
                            err_timeout <= 1'b1;
                            gap_cnt     <= GAP_INIT;
                            state       <= S_GAP;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (eth_clk_stb) begin
                        if (gap_cnt == '0) begin
                            // Carrier activity stands in for a link pulse.
                            idle_cnt <= '0;
                            state    <= S_IDLE;
                            busy     <= 1'b0;
                        end else begin
                            gap_cnt <= gap_cnt - 1'b1;
                        end
                    end
                end
                S_NLP: begin
                    if (eth_clk_stb) begin
                        nlp      <= 1'b0;
                        idle_cnt <= '0;
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tx_sched.sv
// Directed bench for eth_tx_sched: a per-cycle vector table, followed by hand-written multi-strobe
// sequences for the link-pulse period, round-robin, timeout and reset cases.
module tb_eth_tx_sched;

    logic clk = 1'b0;
    logic rst, eth_clk_stb, req_audio, req_beacon, tx_done;
    logic gnt_audio, gnt_beacon, tx_start, tx_sel, nlp, err_timeout, busy;

    int checks = 0;
    int failures = 0;
    int scnt = 0;

    eth_tx_sched #(.IFG_BITS(4), .NLP_PERIOD(20), .MAX_FRAME_BITS(50)) dut (
        .clk(clk), .rst(rst), .eth_clk_stb(eth_clk_stb),
        .req_audio(req_audio), .req_beacon(req_beacon),
        .gnt_audio(gnt_audio), .gnt_beacon(gnt_beacon),
        .tx_start(tx_start), .tx_sel(tx_sel), .tx_done(tx_done),
        .nlp(nlp), .err_timeout(err_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    // Output bundle order: gnt_audio, gnt_beacon, tx_start, tx_sel, nlp, err_timeout, busy
    typedef struct packed {
        logic       rst;
        logic       stb;
        logic       ra;
        logic       rb;
        logic       done;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl [20];

    function automatic logic [6:0] outs();
        return {gnt_audio, gnt_beacon, tx_start, tx_sel, nlp, err_timeout, busy};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the edge, then the strobe phase flips.
    task automatic tick();
        logic was;
        was = eth_clk_stb;
        @(posedge clk);
        #1;
        if (was) scnt++;
        eth_clk_stb = ~eth_clk_stb;
    endtask

    task automatic do_reset();
        rst = 1'b1; eth_clk_stb = 1'b1;
        req_audio = 1'b0; req_beacon = 1'b0; tx_done = 1'b0;
        tick(); tick();
        rst = 1'b0;
        scnt = 0;
    endtask

    // Stop right before the edge that carries strobe number n.
    task automatic goto_strobe(input int n);
        for (int k = 0; k < 400 && !(scnt == n - 1 && eth_clk_stb); k++) tick();
    endtask

    initial begin
        int rise [4];
        int nrise, hi, bm, s0, d, ex, e, bad;
        int who [3];
        int st [3];
        int dn [3];

        rst = 1'b1; eth_clk_stb = 1'b0; req_audio = 1'b0; req_beacon = 1'b0; tx_done = 1'b0;

        //           rst   stb   ra    rb    done  expected outputs
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0000000};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'b0000000};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 7'b1010001};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000001};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0000001};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0000001};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0000001};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000001};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0000001};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000001};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 7'b0000001};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'b0000001};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 7'b0000000};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7'b0000000};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 7'b0111001};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0001001};
        tbl[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 7'b0001001};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0001001};
        tbl[19] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000};

        for (int i = 0; i < 20; i++) begin
            rst = tbl[i].rst; eth_clk_stb = tbl[i].stb;
            req_audio = tbl[i].ra; req_beacon = tbl[i].rb; tx_done = tbl[i].done;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
        end

        // Idle line: a link pulse every 21 strobes, each lasting one strobe period
        do_reset();
        nrise = 0; hi = 0; bm = 0;
        for (int i = 0; i < 140; i++) begin
            logic pn;
            pn = nlp;
            tick();
            if (nlp && !pn) begin
                if (nrise < 4) rise[nrise] = scnt;
                nrise++;
            end
            if (nlp) hi++;
            if (busy !== nlp) bm++;
        end
        chk("nlp_count", nrise, 3);
        chk("nlp_rise0", rise[0], 20);
        chk("nlp_rise1", rise[1], 41);
        chk("nlp_rise2", rise[2], 62);
        chk("nlp_high_cycles", hi, 6);
        chk("nlp_busy_track", bm, 0);

        // Audio request seen at strobe 3, done 10 strobes after start
        do_reset();
        goto_strobe(3);
        chk("t2_pre_grant", 32'(gnt_audio), 0);
        req_audio = 1'b1;
        tick();
        chk("t2_grant", 32'({gnt_audio, gnt_beacon, tx_start, tx_sel}), 32'(4'b1010));
        chk("t2_grant_strobe", scnt, 3);
        req_audio = 1'b0;
        s0 = scnt;
        bad = 0;
        for (int k = 0; k < 100 && scnt < s0 + 10; k++) begin
            tick();
            if (tx_sel !== 1'b0 || busy !== 1'b1) bad++;
        end
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        d = scnt;
        for (int k = 0; k < 100 && busy; k++) begin
            if (tx_sel !== 1'b0) bad++;
            tick();
        end
        chk("t2_busy_low", 32'(busy), 0);
        chk("t2_gap_strobes", scnt - d, 4);
        chk("t2_sel_stable", bad, 0);

        // Both requests held: round-robin audio, beacon, audio
        do_reset();
        req_audio = 1'b1; req_beacon = 1'b1;
        for (int g = 0; g < 3; g++) begin
            for (int k = 0; k < 100 && !tx_start; k++) tick();
            who[g] = tx_start ? int'(gnt_beacon) : 2;
            st[g] = scnt;
            for (int k = 0; k < 100 && scnt < st[g] + 5; k++) tick();
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
            dn[g] = scnt;
        end
        req_audio = 1'b0; req_beacon = 1'b0;
        chk("t3_grant0_audio", who[0], 0);
        chk("t3_grant1_beacon", who[1], 1);
        chk("t3_grant2_audio", who[2], 0);
        chk("t3_gap1", st[1] - dn[0], 5);
        chk("t3_gap2", st[2] - dn[1], 5);

        // Frame request on the strobe where the link pulse falls due
        do_reset();
        goto_strobe(20);
        req_beacon = 1'b1;
        tick();
        chk("t4_frame_wins", 32'({tx_start, gnt_beacon, nlp}), 32'(3'b110));
        req_beacon = 1'b0;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        d = scnt;
        bad = 0;
        for (int k = 0; k < 100 && busy; k++) begin
            if (nlp) bad++;
            tick();
        end
        ex = scnt;
        chk("t4_gap", ex - d, 4);
        for (int k = 0; k < 200 && !nlp; k++) tick();
        chk("t4_nlp_seen", 32'(nlp), 1);
        chk("t4_nlp_after_gap", scnt - ex, 20);
        chk("t4_no_nlp_in_frame", bad, 0);

        // Timeout: no tx_done after the grant
        do_reset();
        req_audio = 1'b1;
        tick();
        chk("t5_grant", 32'(gnt_audio), 1);
        req_audio = 1'b0;
        s0 = scnt;
        for (int k = 0; k < 300 && !err_timeout; k++) tick();
        e = scnt;
        chk("t5_err_seen", 32'(err_timeout), 1);
        chk("t5_err_strobe", e - s0, 50);
        req_beacon = 1'b1;
        tick();
        chk("t5_err_one_cycle", 32'(err_timeout), 0);
        for (int k = 0; k < 100 && !tx_start; k++) tick();
        chk("t5_next_grant", 32'({tx_start, gnt_beacon}), 32'(2'b11));
        chk("t5_next_grant_strobe", scnt - e, 5);
        req_beacon = 1'b0;

        // Reset in the middle of a beacon frame
        do_reset();
        req_beacon = 1'b1;
        tick();
        chk("t6_beacon_sel", 32'({gnt_beacon, tx_sel}), 32'(2'b11));
        req_beacon = 1'b0;
        tick(); tick(); tick();
        req_audio = 1'b1; req_beacon = 1'b1; rst = 1'b1;
        tick();
        chk("t6_reset_outs", 32'(outs()), 0);
        rst = 1'b0;
        for (int k = 0; k < 10 && !tx_start; k++) tick();
        chk("t6_audio_first", 32'({tx_start, gnt_audio, gnt_beacon, tx_sel}), 32'(4'b1100));
        req_audio = 1'b0; req_beacon = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
